trace_window_ctrl: RTL and testbench
====================================

TRACE_WINDOW_CTRL -- requirements
Module: trace_window_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the start, length and cycle counter fields.
REQ-002 SHALL have parameter DEF_EN, default 0: reset value of the trace-enable config.
REQ-003 SHALL have parameter DEF_START, default 0: reset value of the start delay in cycles.
REQ-004 SHALL have parameter DEF_LEN, default 0: reset value of the window length in cycles; 0 means unlimited.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port cfg_valid, input, 1: config write request.
REQ-008 SHALL have port cfg_ready, output, 1: config write accepted when high together with cfg_valid.
REQ-009 SHALL have port cfg_en, input, 1: trace-enable value to write.
REQ-010 SHALL have port cfg_start, input, CNT_W: start delay to write.
REQ-011 SHALL have port cfg_len, input, CNT_W: window length to write.
REQ-012 SHALL have port arm, input, 1: single-cycle request to begin a trace sequence.
REQ-013 SHALL have port stop, input, 1: early-terminate request.
REQ-014 SHALL have port trace_on, output, 1: high while the trace window is open.
REQ-015 SHALL have port flush_req, output, 1: request to the dump sink to flush.
REQ-016 SHALL have port flush_ack, input, 1: flush completion from the dump sink.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse when a sequence completes.
REQ-019 SHALL have port cycle_cnt, output, CNT_W: current phase counter.

Function
REQ-020 SHALL implement the states IDLE, WAIT, ACTIVE and FLUSH; all outputs SHALL be registered except cfg_ready and flush_req, which SHALL be decoded from state.
REQ-021 cfg_ready SHALL be 1 only in IDLE; on cfg_valid&&cfg_ready the block SHALL capture en, start and len; writes attempted outside IDLE SHALL be dropped.
REQ-022 When arm is high in IDLE with enable=0, the block SHALL ignore arm and remain in IDLE with no done pulse.
REQ-023 When arm is high in IDLE with enable=1, the block SHALL clear cycle_cnt to 0 and go to WAIT if start!=0, or directly to ACTIVE if start==0.
REQ-024 If cfg_valid&&cfg_ready and arm are high in the same cycle, arm SHALL use the config being written in that cycle (en, start and len).
REQ-025 In WAIT, cycle_cnt SHALL increment by 1 per cycle; when cycle_cnt==start-1 the next state SHALL be ACTIVE and cycle_cnt SHALL be cleared to 0, so trace_on rises exactly start cycles after the arm cycle.
REQ-026 In ACTIVE, trace_on SHALL be 1 and cycle_cnt SHALL increment per cycle.
REQ-027 If len!=0, trace_on SHALL stay high for exactly len cycles, leaving ACTIVE when cycle_cnt==len-1.
REQ-028 If len==0, the block SHALL stay in ACTIVE until stop; cycle_cnt SHALL saturate at all-ones with no wrap.
REQ-029 stop in WAIT or ACTIVE SHALL go to FLUSH on the next edge; stop SHALL take priority over a same-cycle ACTIVE or length-expiry transition; stop in IDLE or FLUSH SHALL be ignored.
REQ-030 In FLUSH, trace_on SHALL be 0 and flush_req SHALL be 1 until flush_ack is sampled high.
REQ-031 On flush_req&&flush_ack the block SHALL go to IDLE and pulse done for exactly one cycle.
REQ-032 flush_ack outside FLUSH SHALL be ignored.
REQ-033 arm outside IDLE SHALL be ignored and SHALL NOT queue.
REQ-034 busy SHALL equal (state!=IDLE).

Reset
REQ-035 On reset assertion, immediately and regardless of clk: state=IDLE, trace_on=0, done=0, cycle_cnt=0, flush_req=0, en=DEF_EN, start=DEF_START, len=DEF_LEN.
REQ-036 Reset mid-sequence SHALL abort without a flush request or done pulse.
REQ-037 The first arm SHALL be honoured on the first rising clk edge after reset deasserts.

Verification
REQ-038 Write en=1, start=3, len=4, then arm -> trace_on high on cycles 3..6 after arm, then flush_req; ack one cycle later -> done pulses once.
REQ-039 start=0, len=1, arm -> trace_on high for exactly 1 cycle beginning the cycle after arm.
REQ-040 en=0, arm -> busy stays 0, no trace_on, no done.
REQ-041 len=0, arm, stop asserted 10 cycles into ACTIVE -> FLUSH entered; flush_ack held low for 5 cycles -> flush_req held for those 5 cycles.
REQ-042 cfg_valid during ACTIVE with a new len -> cfg_ready=0, current window length unchanged.
REQ-043 Reset asserted in WAIT -> all outputs at reset values immediately; config returns to DEF_* values.

Source files
------------

// File: rtl/trace_window_ctrl.sv
// trace_window_ctrl: arms a trace window that opens after a programmable start delay.
// The window stays open for len cycles, or until stop when len is 0. The block then
// requests a flush from the dump sink and pulses done once the sink acknowledges.
// Ports: clk/reset (async, active-high); cfg_valid/cfg_ready + cfg_en/cfg_start/cfg_len
//        config write (IDLE only); arm/stop control; trace_on/busy/done/cycle_cnt status;
//        flush_req/flush_ack handshake with the dump sink.
module trace_window_ctrl #(
  parameter int               CNT_W     = 32,
  parameter bit               DEF_EN    = 1'b0,
  parameter logic [CNT_W-1:0] DEF_START = '0,
  parameter logic [CNT_W-1:0] DEF_LEN   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_start,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             arm,
  input  logic             stop,
  output logic             trace_on,
  output logic             flush_req,
  input  logic             flush_ack,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_FLUSH} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             r_en;
  logic [CNT_W-1:0] r_start;
  logic [CNT_W-1:0] r_len;
  logic             r_trace_on;
  logic             r_busy;
  logic             r_done;
  logic             w_cfg_wr;
  logic             w_en;
  logic [CNT_W-1:0] w_start;
  logic             w_next_done;

  assign w_cfg_wr = cfg_valid && (r_state == S_IDLE);

  // An arm in the same cycle as a config write sees the value being written.
  // The length needs no bypass: it lands in r_len on the same edge and is not
  // consulted until ACTIVE.
  assign w_en    = w_cfg_wr ? cfg_en    : r_en;
  assign w_start = w_cfg_wr ? cfg_start : r_start;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (arm && w_en) begin
          w_next_cnt   = '0;
          w_next_state = (w_start == '0) ? S_ACTIVE : S_WAIT;
        end
      end
      S_WAIT: begin
        // stop wins over the WAIT->ACTIVE hand-off; the counter freezes on exit
        if (stop) begin
          w_next_state = S_FLUSH;
        end else if (r_cnt == r_start - ONE) begin
          w_next_state = S_ACTIVE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + ONE;
        end
      end
      S_ACTIVE: begin
        if (stop) begin
          w_next_state = S_FLUSH;
        end else if ((r_len != '0) && (r_cnt == r_len - ONE)) begin
          w_next_state = S_FLUSH;
        end else if (r_cnt != CNT_MAX) begin
          // saturate so an unlimited window never wraps back to small counts
          w_next_cnt = r_cnt + ONE;
        end
      end
      S_FLUSH: begin
        if (flush_ack) begin
          w_next_state = S_IDLE;
          w_next_done  = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_trace_on <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_trace_on <= (w_next_state == S_ACTIVE);
      r_busy     <= (w_next_state != S_IDLE);
      r_done     <= w_next_done;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en    <= DEF_EN;
      r_start <= DEF_START;
      r_len   <= DEF_LEN;
    end else if (w_cfg_wr) begin
      r_en    <= cfg_en;
      r_start <= cfg_start;
      r_len   <= cfg_len;
    end
  end

  assign cfg_ready = (r_state == S_IDLE);
  assign flush_req = (r_state == S_FLUSH);
  assign trace_on  = r_trace_on;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_trace_window_ctrl.sv
// tb_trace_window_ctrl: directed stimulus for trace_window_ctrl with a timestamp-based
// reference model compared on every clock, plus hand-computed waveform expectations.
// Ports: none (top-level bench).
module tb_trace_window_ctrl;

  localparam int     TW   = 8;
  localparam longint MAXC = 255;
  localparam longint INF  = 64'd1 << 40;

  logic          clk;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_en;
  logic [TW-1:0] cfg_start;
  logic [TW-1:0] cfg_len;
  logic          arm;
  logic          stop;
  logic          trace_on;
  logic          flush_req;
  logic          flush_ack;
  logic          busy;
  logic          done;
  logic [TW-1:0] cycle_cnt;

  int tot = 0;
  int bad = 0;

  trace_window_ctrl #(
    .CNT_W    (TW),
    .DEF_EN   (1'b1),
    .DEF_START(8'd2),
    .DEF_LEN  (8'd3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_en   (cfg_en),
    .cfg_start(cfg_start),
    .cfg_len  (cfg_len),
    .arm      (arm),
    .stop     (stop),
    .trace_on (trace_on),
    .flush_req(flush_req),
    .flush_ack(flush_ack),
    .busy     (busy),
    .done     (done),
    .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tot++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a sequence is described by the edge it was armed on, its
  // config, and the edge stop was accepted on; everything else is arithmetic.
  longint n      = 0;
  longint t_arm  = 0;
  longint t_stop = INF;
  longint t_done = -1;
  longint m_start = 2;
  longint m_len   = 3;
  longint m_cnt   = 0;
  bit     m_en    = 1'b1;
  bit     m_busy  = 1'b0;

  function automatic longint close_edge();
    longint ex;
    ex = (m_len != 0) ? t_arm + m_start + m_len : INF;
    return (t_stop < ex) ? t_stop : ex;
  endfunction

  // 1 = delay, 2 = window open, 3 = flushing (for the cycle following edge k)
  function automatic int phase(input longint k);
    if (k >= close_edge()) return 3;
    if (k >= t_arm + m_start) return 2;
    return 1;
  endfunction

  function automatic longint cnt_at(input longint k);
    longint act;
    act = t_arm + m_start;
    if (k >= act) return (k - act > MAXC) ? MAXC : k - act;
    return k - t_arm;
  endfunction

  always @(posedge clk) begin
    n = n + 1;
    if (reset) begin
      m_busy  = 1'b0;
      m_en    = 1'b1;
      m_start = 2;
      m_len   = 3;
      m_cnt   = 0;
      t_done  = -1;
    end else if (!m_busy) begin
      if (cfg_valid) begin
        m_en    = cfg_en;
        m_start = cfg_start;
        m_len   = cfg_len;
      end
      if (arm && m_en) begin
        t_arm  = n;
        t_stop = INF;
        m_busy = 1'b1;
      end
    end else begin
      if (phase(n - 1) != 3) begin
        if (stop) t_stop = n;
      end else if (flush_ack) begin
        m_busy = 1'b0;
        t_done = n;
      end
    end
    if (m_busy) m_cnt = (n >= close_edge()) ? cnt_at(close_edge() - 1) : cnt_at(n);
    #1;
    chk("m_busy", busy, m_busy);
    chk("m_cfg_ready", cfg_ready, !m_busy);
    chk("m_trace_on", trace_on, m_busy && (phase(n) == 2));
    chk("m_flush_req", flush_req, m_busy && (phase(n) == 3));
    chk("m_done", done, t_done == n);
    chk("m_cycle_cnt", cycle_cnt, m_cnt);
  end

  logic [31:0] vt, vf, vd, vb;
  logic [TW-1:0] cnt_log [32];

  // Records outputs for cycles k = 0..len-1, leaving the caller in cycle k = len.
  task automatic rec(input int len);
    vt = '0; vf = '0; vd = '0; vb = '0;
    for (int k = 0; k < len; k++) begin
      vt[k] = trace_on;
      vf[k] = flush_req;
      vd[k] = done;
      vb[k] = busy;
      cnt_log[k] = cycle_cnt;
      @(negedge clk);
    end
  endtask

  task automatic cfg_write(input logic en, input int st, input int ln);
    cfg_valid = 1'b1;
    cfg_en    = en;
    cfg_start = TW'(st);
    cfg_len   = TW'(ln);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic ack_done(input string name);
    flush_ack = 1'b1;
    @(negedge clk);
    chk({name, "_done_hi"}, done, 1);
    chk({name, "_busy_lo"}, busy, 0);
    flush_ack = 1'b0;
    @(negedge clk);
    chk({name, "_done_lo"}, done, 0);
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_en = 1'b0; cfg_start = '0; cfg_len = '0;
    arm = 1'b0; stop = 1'b0; flush_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_trace", trace_on, 0);
    chk("rst_flush", flush_req, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_cfg_ready", cfg_ready, 1);

    // first arm right after reset release uses the defaults (en=1, start=2, len=3)
    reset = 1'b0;
    arm_pulse();
    rec(8);
    chk("A_trace", vt[7:0], 8'b0001_1100);
    chk("A_flush", vf[7:0], 8'b1110_0000);
    chk("A_cnt_k4", cnt_log[4], 2);
    ack_done("A");

    // start=3, len=4
    cfg_write(1'b1, 3, 4);
    arm_pulse();
    rec(8);
    chk("B_trace", vt[7:0], 8'b0111_1000);
    chk("B_flush", vf[7:0], 8'b1000_0000);
    chk("B_done_none", vd[7:0], 0);
    chk("B_cnt_wait", cnt_log[2], 2);
    chk("B_cnt_last", cnt_log[6], 3);
    ack_done("B");

    // start=0, len=1: one-cycle window right after arm
    cfg_write(1'b1, 0, 1);
    arm_pulse();
    rec(4);
    chk("C_trace", vt[3:0], 4'b0001);
    chk("C_flush", vf[3:0], 4'b1110);
    ack_done("C");

    // disabled: arm ignored
    cfg_write(1'b0, 1, 1);
    arm_pulse();
    rec(5);
    chk("D_busy", vb[4:0], 0);
    chk("D_trace", vt[4:0], 0);
    chk("D_done", vd[4:0], 0);

    // config write and arm in the same cycle: the new config applies
    cfg_valid = 1'b1; cfg_en = 1'b1; cfg_start = 8'd1; cfg_len = 8'd2; arm = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; arm = 1'b0;
    rec(5);
    chk("F_trace", vt[4:0], 5'b00110);
    chk("F_flush", vf[4:0], 5'b11000);
    ack_done("F");

    // unlimited window, rejected write mid-window, stop after 10 cycles, slow ack
    cfg_write(1'b1, 0, 0);
    arm_pulse();
    vt = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        cfg_valid = 1'b1; cfg_len = 8'd2;
        chk("E_cfg_ready", cfg_ready, 0);
      end
      if (k == 6) cfg_valid = 1'b0;
      vt[k] = trace_on;
      @(negedge clk);
    end
    chk("E_trace_held", vt[9:0], 10'h3FF);
    chk("E_cnt_10", cycle_cnt, 10);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("E_trace_off", trace_on, 0);
    chk("E_flush_on", flush_req, 1);
    rec(5);
    chk("E_flush_hold", vf[4:0], 5'b11111);
    chk("E_cnt_frozen", cnt_log[0], 10);
    ack_done("E");

    // counter saturates in an unlimited window
    cfg_write(1'b1, 0, 0);
    arm_pulse();
    repeat (260) @(negedge clk);
    chk("S_cnt_sat", cycle_cnt, 255);
    chk("S_trace", trace_on, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    ack_done("S");

    // stop during the delay, arm while busy ignored
    cfg_write(1'b1, 5, 2);
    arm_pulse();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("G_flush", flush_req, 1);
    chk("G_cnt", cycle_cnt, 2);
    rec(3);
    chk("G_trace", vt[2:0], 0);
    ack_done("G");
    // stop and flush_ack in IDLE are ignored, and the earlier arm did not queue
    stop = 1'b1; flush_ack = 1'b1;
    rec(3);
    stop = 1'b0; flush_ack = 1'b0;
    chk("G_idle_busy", vb[2:0], 0);
    chk("G_idle_done", vd[2:0], 0);

    // reset during the delay: immediate return to reset values and defaults
    cfg_write(1'b1, 4, 4);
    arm_pulse();
    repeat (2) @(negedge clk);
    chk("H_cnt_pre", cycle_cnt, 2);
    #2 reset = 1'b1;
    #1;
    chk("H_busy", busy, 0);
    chk("H_cnt", cycle_cnt, 0);
    chk("H_trace", trace_on, 0);
    chk("H_flush", flush_req, 0);
    chk("H_done", done, 0);
    chk("H_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    arm_pulse();
    rec(6);
    chk("H_def_trace", vt[5:0], 6'b011100);
    chk("H_def_flush", vf[5:0], 6'b100000);
    chk("H_no_done", vd[5:0], 0);
    ack_done("H");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
